// File: rtl/hangman_word_tracker.sv
// Letter-reveal engine for the word-guessing game: holds the secret word, a sticky
// reveal mask, guess history and miss count, and resolves one guess per two cycles.
module hangman_word_tracker #(
    parameter int                WORD_LEN   = 7,
    parameter int                CHAR_W     = 7,
    parameter int                MAX_MISSES = 6,
    parameter logic [CHAR_W-1:0] BLANK_CHAR = 7'h5F
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load,
    input  logic [WORD_LEN*CHAR_W-1:0]         word_in,
    input  logic                               guess_valid,
    input  logic [CHAR_W-1:0]                  guess_char,
    output logic                               guess_ready,
    output logic [WORD_LEN*CHAR_W-1:0]         display_out,
    output logic [WORD_LEN-1:0]                reveal_mask,
    output logic [$clog2(MAX_MISSES+1)-1:0]    miss_count,
    output logic                               result_valid,
    output logic                               result_hit,
    output logic                               result_repeat,
    output logic                               game_won,
    output logic                               game_lost
);

    localparam int                 MISS_W   = $clog2(MAX_MISSES + 1);
    localparam logic [MISS_W-1:0]  MISS_MAX = MISS_W'(MAX_MISSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_WON,
        S_LOST
    } state_t;

    state_t                         state_reg, state_next;
    logic [WORD_LEN*CHAR_W-1:0]     word_reg, word_next;
    logic [WORD_LEN-1:0]            mask_reg, mask_next;
    logic [2**CHAR_W-1:0]           history_reg, history_next;
    logic [MISS_W-1:0]              miss_reg, miss_next;
    logic [CHAR_W-1:0]              guess_reg, guess_next;
    logic                           result_valid_reg, result_valid_next;
    logic                           result_hit_reg, result_hit_next;
    logic                           result_repeat_reg, result_repeat_next;
    logic [WORD_LEN-1:0]            match;

    // Per-slot compare against the latched guess and per-slot display mux.
    generate
        for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_slot
            assign match[gi] = (word_reg[gi*CHAR_W +: CHAR_W] == guess_reg);
            assign display_out[gi*CHAR_W +: CHAR_W] =
                mask_reg[gi] ? word_reg[gi*CHAR_W +: CHAR_W] : BLANK_CHAR;
        end
    endgenerate

    always_comb begin
        state_next         = state_reg;
        word_next          = word_reg;
        mask_next          = mask_reg;
        history_next       = history_reg;
        miss_next          = miss_reg;
        guess_next         = guess_reg;
        result_valid_next  = 1'b0;
        result_hit_next    = result_hit_reg;
        result_repeat_next = result_repeat_reg;

        if (load) begin
            // New game wins over anything else, including a guess offered this cycle.
            word_next          = word_in;
            mask_next          = '0;
            history_next       = '0;
            miss_next          = '0;
            result_hit_next    = 1'b0;
            result_repeat_next = 1'b0;
            state_next         = S_PLAY;
        end else begin
            case (state_reg)
                S_PLAY: begin
                    if (guess_valid) begin
                        guess_next = guess_char;
                        state_next = S_CHECK;
                    end
                end
                S_CHECK: begin
                    result_valid_next = 1'b1;
                    result_hit_next   = |match;
                    if (history_reg[guess_reg]) begin
                        result_repeat_next = 1'b1;
                    end else begin
                        result_repeat_next      = 1'b0;
                        history_next[guess_reg] = 1'b1;
                        mask_next               = mask_reg | match;
                        if (!(|match) && (miss_reg != MISS_MAX)) begin
                            miss_next = miss_reg + MISS_W'(1);
                        end
                    end
                    // Win is judged first on the updated mask; a hit can never be a miss.
                    if (&mask_next) begin
                        state_next = S_WON;
                    end else if (miss_next == MISS_MAX) begin
                        state_next = S_LOST;
                    end else begin
                        state_next = S_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= S_IDLE;
            word_reg          <= '0;
            mask_reg          <= '0;
            history_reg       <= '0;
            miss_reg          <= '0;
            guess_reg         <= '0;
            result_valid_reg  <= 1'b0;
            result_hit_reg    <= 1'b0;
            result_repeat_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            word_reg          <= word_next;
            mask_reg          <= mask_next;
            history_reg       <= history_next;
            miss_reg          <= miss_next;
            guess_reg         <= guess_next;
            result_valid_reg  <= result_valid_next;
            result_hit_reg    <= result_hit_next;
            result_repeat_reg <= result_repeat_next;
        end
    end

    assign guess_ready   = (state_reg == S_PLAY);
    assign reveal_mask   = mask_reg;
    assign miss_count    = miss_reg;
    assign result_valid  = result_valid_reg;
    assign result_hit    = result_hit_reg;
    assign result_repeat = result_repeat_reg;
    assign game_won      = (state_reg == S_WON);
    assign game_lost     = (state_reg == S_LOST);

endmodule

// File: tb/tb_hangman_word_tracker.sv
// Bench for hangman_word_tracker: directed game scenarios plus randomized play, all
// checked every cycle against a letter-level game model.
module tb_hangman_word_tracker;

    localparam int WORD_LEN   = 7;
    localparam int CHAR_W     = 7;
    localparam int MAX_MISSES = 6;
    localparam int MISS_W     = $clog2(MAX_MISSES + 1);
    localparam logic [CHAR_W-1:0] BLANK = 7'h5F;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          load = 1'b0;
    logic [WORD_LEN*CHAR_W-1:0]    word_in = '0;
    logic                          guess_valid = 1'b0;
    logic [CHAR_W-1:0]             guess_char = '0;
    logic                          guess_ready;
    logic [WORD_LEN*CHAR_W-1:0]    display_out;
    logic [WORD_LEN-1:0]           reveal_mask;
    logic [MISS_W-1:0]             miss_count;
    logic                          result_valid;
    logic                          result_hit;
    logic                          result_repeat;
    logic                          game_won;
    logic                          game_lost;

    hangman_word_tracker #(
        .WORD_LEN(WORD_LEN), .CHAR_W(CHAR_W), .MAX_MISSES(MAX_MISSES), .BLANK_CHAR(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .word_in(word_in),
        .guess_valid(guess_valid), .guess_char(guess_char), .guess_ready(guess_ready),
        .display_out(display_out), .reveal_mask(reveal_mask), .miss_count(miss_count),
        .result_valid(result_valid), .result_hit(result_hit), .result_repeat(result_repeat),
        .game_won(game_won), .game_lost(game_lost)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: the secret letters, which letters are shown, letters tried so far.
    typedef enum {G_IDLE, G_PLAY, G_CHECK, G_WON, G_LOST} phase_t;
    phase_t  m_phase;
    byte     m_word[WORD_LEN];
    bit      m_shown[WORD_LEN];
    bit      m_tried[2**CHAR_W];
    int      m_miss;
    byte     m_pending;
    bit      m_rv, m_hit, m_rep;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = G_IDLE;
        foreach (m_word[i]) begin m_word[i] = 0; m_shown[i] = 0; end
        foreach (m_tried[i]) m_tried[i] = 0;
        m_miss = 0; m_pending = 0; m_rv = 0; m_hit = 0; m_rep = 0;
    endtask

    // One clock edge of the game as seen from the inputs presented before it.
    task automatic model_step();
        bit any, all_shown;
        m_rv = 0;
        if (load) begin
            foreach (m_word[i]) begin
                m_word[i]  = byte'(word_in[i*CHAR_W +: CHAR_W]);
                m_shown[i] = 0;
            end
            foreach (m_tried[i]) m_tried[i] = 0;
            m_miss = 0; m_hit = 0; m_rep = 0;
            m_phase = G_PLAY;
        end else if (m_phase == G_PLAY) begin
            if (guess_valid) begin
                m_pending = byte'(guess_char);
                m_phase   = G_CHECK;
            end
        end else if (m_phase == G_CHECK) begin
            any = 0;
            foreach (m_word[i]) if (m_word[i] == m_pending) any = 1;
            m_rv = 1; m_hit = any;
            if (m_tried[m_pending]) begin
                m_rep = 1;
            end else begin
                m_rep = 0;
                m_tried[m_pending] = 1;
                foreach (m_word[i]) if (m_word[i] == m_pending) m_shown[i] = 1;
                if (!any && m_miss < MAX_MISSES) m_miss++;
            end
            all_shown = 1;
            foreach (m_shown[i]) if (!m_shown[i]) all_shown = 0;
            if (all_shown)                m_phase = G_WON;
            else if (m_miss == MAX_MISSES) m_phase = G_LOST;
            else                          m_phase = G_PLAY;
        end
    endtask

    task automatic check_all();
        logic [WORD_LEN*CHAR_W-1:0] exp_disp;
        logic [WORD_LEN-1:0]        exp_mask;
        for (int i = 0; i < WORD_LEN; i++) begin
            exp_disp[i*CHAR_W +: CHAR_W] = m_shown[i] ? CHAR_W'(m_word[i]) : BLANK;
            exp_mask[i] = m_shown[i];
        end
        chk("guess_ready", guess_ready, m_phase == G_PLAY);
        chk("display_out", display_out, exp_disp);
        chk("reveal_mask", reveal_mask, exp_mask);
        chk("miss_count", miss_count, m_miss);
        chk("result_valid", result_valid, m_rv);
        if (m_rv) begin
            chk("result_hit", result_hit, m_hit);
            chk("result_repeat", result_repeat, m_rep);
        end
        chk("game_won", game_won, m_phase == G_WON);
        chk("game_lost", game_lost, m_phase == G_LOST);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_word(input string s);
        for (int i = 0; i < WORD_LEN; i++) word_in[i*CHAR_W +: CHAR_W] = CHAR_W'(s[i]);
    endtask

    task automatic do_load(input string s);
        set_word(s);
        load = 1'b1;
        tick();
        load = 1'b0;
        $display("load %s", s);
    endtask

    task automatic do_guess(input byte c);
        guess_valid = 1'b1;
        guess_char  = CHAR_W'(c);
        tick();
        guess_valid = 1'b0;
        chk("ready_drop", guess_ready, 0);
        tick();
        $display("guess %c -> hit=%0b repeat=%0b miss=%0d mask=%b", c, result_hit,
                 result_repeat, miss_count, reveal_mask);
    endtask

    // Reset raised between edges, held across one edge, released after it.
    task automatic pulse_reset();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        $display("reset pulse");
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        chk("reset_display", display_out, {WORD_LEN{BLANK}});
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        do_load("HANGMAN");
        chk("lit_ready", guess_ready, 1);
        chk("lit_blank", display_out, {WORD_LEN{BLANK}});

        do_guess("A");
        chk("lit_A_mask", reveal_mask, 7'b0100010);
        chk("lit_A_slot1", display_out[1*CHAR_W +: CHAR_W], 7'h41);
        chk("lit_A_hit", result_hit, 1);
        do_guess("A");
        chk("lit_AA_rep", result_repeat, 1);
        chk("lit_AA_miss", miss_count, 0);
        do_guess("Z");
        chk("lit_Z_miss", miss_count, 1);
        chk("lit_Z_hit", result_hit, 0);
        do_guess("Z");
        chk("lit_ZZ_miss", miss_count, 1);
        do_guess("H"); do_guess("N"); do_guess("G"); do_guess("M");
        chk("lit_won_mask", reveal_mask, 7'h7F);
        chk("lit_won", game_won, 1);
        chk("lit_won_ready", guess_ready, 0);
        guess_valid = 1'b1; guess_char = 7'h51;
        tick(); tick();
        guess_valid = 1'b0;

        do_load("HANGMAN");
        do_guess("B"); do_guess("C"); do_guess("D");
        do_guess("E"); do_guess("F"); do_guess("I");
        chk("lit_lost_miss", miss_count, 6);
        chk("lit_lost", game_lost, 1);
        guess_valid = 1'b1; guess_char = 7'h4A;
        tick(); tick();
        guess_valid = 1'b0;
        chk("lit_lost_hold", miss_count, 6);

        do_load("ABCDEFG");
        set_word("GGGGGGG");
        load = 1'b1; guess_valid = 1'b1; guess_char = 7'h47;
        tick();
        load = 1'b0;
        chk("lit_load_drop_ready", guess_ready, 1);
        chk("lit_load_drop_mask", reveal_mask, 0);
        tick();
        guess_valid = 1'b0;
        pulse_reset();
        chk("lit_rst_rv", result_valid, 0);
        tick();
        chk("lit_rst_rv2", result_valid, 0);

        // Randomized play over a small alphabet so wins, losses and repeats all occur.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                pulse_reset();
            end else begin
                load = (r < 6);
                if (load)
                    for (int i = 0; i < WORD_LEN; i++)
                        word_in[i*CHAR_W +: CHAR_W] = CHAR_W'(8'h41 + $urandom_range(0, 5));
                guess_valid = ($urandom_range(0, 3) != 0);
                guess_char  = CHAR_W'(8'h41 + $urandom_range(0, 9));
                tick();
                if (result_valid)
                    $display("rand guess -> hit=%0b repeat=%0b miss=%0d mask=%b",
                             result_hit, result_repeat, miss_count, reveal_mask);
            end
        end
        load = 1'b0; guess_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
